// File: rtl/mult_sequencer_pkg.sv
// Shared types and defaults for the execute-stage multiplier sequencer.
// The state encoding is exported so checkers can decode the debug state.
package mult_sequencer_pkg;

   localparam int MSEQ_WORD           = 64;
   localparam int MSEQ_TIMEOUT_CYCLES = 80;
   localparam int MSEQ_CNT_W          = 7;

   typedef enum logic [2:0] {
      MSEQ_IDLE  = 3'd0,
      MSEQ_START = 3'd1,
      MSEQ_BUSY  = 3'd2,
      MSEQ_DONE  = 3'd3,
      MSEQ_DRAIN = 3'd4
   } mseq_state_t;

   // States in which the multiplier owns the pipeline regardless of decode.
   function automatic logic mseq_is_active(mseq_state_t s);
      return (s == MSEQ_START) || (s == MSEQ_BUSY) || (s == MSEQ_DRAIN);
   endfunction

endpackage

// File: rtl/mult_sequencer_if.sv
// Decode / multiplier / writeback signal bundle around the multiply sequencer.
// Handshake: decode holds mul_req (with mode/rd) as a level while stall=1 and a
// request is taken in the first IDLE/DONE cycle with mul_req=1 and flush=0;
// mult_start, mult_done and result_valid are single-cycle pulses with no back-pressure.
interface mult_sequencer_if #(
   parameter int WORD = mult_sequencer_pkg::MSEQ_WORD
);
   import mult_sequencer_pkg::*;

   logic            mul_req;
   logic [1:0]      mul_mode_in;
   logic [4:0]      mul_rd;
   logic            flush;
   logic            mult_done;
   logic [WORD-1:0] mult_result;

   logic            mult_start;
   logic [1:0]      mult_mode;
   logic            stall;
   logic            execute_result_loc;
   logic [WORD-1:0] result;
   logic            result_valid;
   logic [4:0]      result_rd;
   logic            timeout_err;
   mseq_state_t     dbg_state;

   modport master (
      output mul_req, mul_mode_in, mul_rd, flush, mult_done, mult_result,
      input  mult_start, mult_mode, stall, execute_result_loc, result,
             result_valid, result_rd, timeout_err, dbg_state
   );

   modport slave (
      input  mul_req, mul_mode_in, mul_rd, flush, mult_done, mult_result,
      output mult_start, mult_mode, stall, execute_result_loc, result,
             result_valid, result_rd, timeout_err, dbg_state
   );

endinterface

// File: rtl/mult_sequencer_timeout_counter.sv
// Watchdog counter for an outstanding multiply; o_tc flags the last allowed
// cycle and the count parks there so a late flush cannot wrap it around.
module mult_sequencer_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 80,
   parameter int CNT_W          = 7
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_tc
);

   localparam logic [CNT_W-1:0] LP_TC = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_count;
   logic             w_tc;

   assign w_tc = (r_count >= LP_TC);
   assign o_tc = w_tc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && !w_tc) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mult_sequencer.sv
// Sequences one multi-cycle multiply at a time: start pulse, pipeline stall,
// result capture for writeback, flush draining and lost-done timeout.
module mult_sequencer
   import mult_sequencer_pkg::*;
#(
   parameter int WORD           = MSEQ_WORD,
   parameter int TIMEOUT_CYCLES = MSEQ_TIMEOUT_CYCLES,
   parameter int CNT_W          = MSEQ_CNT_W
) (
   input logic             clk,
   input logic             reset,
   mult_sequencer_if.slave bus
);

   mseq_state_t     r_state;
   logic            r_mult_start;
   logic            r_result_valid;
   logic            r_exec_loc;
   logic            r_timeout_err;
   logic [1:0]      r_mult_mode;
   logic [4:0]      r_rd;
   logic [4:0]      r_result_rd;
   logic [WORD-1:0] r_result;

   logic w_accept;
   logic w_tc;
   logic w_cnt_clear;
   logic w_cnt_enable;
   logic w_stall;

   assign w_accept     = bus.mul_req & ~bus.flush;
   assign w_cnt_clear  = (r_state == MSEQ_START);
   assign w_cnt_enable = (r_state == MSEQ_BUSY) | (r_state == MSEQ_DRAIN);

   // Stall is combinational so decode freezes in the very cycle a request is taken.
   assign w_stall = mseq_is_active(r_state) |
                    (((r_state == MSEQ_IDLE) | (r_state == MSEQ_DONE)) & w_accept);

   mult_sequencer_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (w_cnt_clear),
      .i_enable (w_cnt_enable),
      .o_tc     (w_tc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= MSEQ_IDLE;
         r_mult_start   <= 1'b0;
         r_result_valid <= 1'b0;
         r_exec_loc     <= 1'b0;
         r_timeout_err  <= 1'b0;
         r_mult_mode    <= '0;
         r_rd           <= '0;
         r_result_rd    <= '0;
         r_result       <= '0;
      end else begin
         r_mult_start   <= 1'b0;
         r_result_valid <= 1'b0;
         r_exec_loc     <= 1'b0;
         case (r_state)
            MSEQ_IDLE, MSEQ_DONE: begin
               if (w_accept) begin
                  r_mult_mode  <= bus.mul_mode_in;
                  r_rd         <= bus.mul_rd;
                  r_mult_start <= 1'b1;
                  r_state      <= MSEQ_START;
               end else begin
                  r_state <= MSEQ_IDLE;
               end
            end
            MSEQ_START: begin
               r_state <= bus.flush ? MSEQ_DRAIN : MSEQ_BUSY;
            end
            MSEQ_BUSY: begin
               // A done coinciding with flush retires the op, so nothing is left to drain.
               if (bus.flush) begin
                  r_state <= bus.mult_done ? MSEQ_IDLE : MSEQ_DRAIN;
               end else if (bus.mult_done) begin
                  r_result       <= bus.mult_result;
                  r_result_rd    <= r_rd;
                  r_result_valid <= 1'b1;
                  r_exec_loc     <= 1'b1;
                  r_state        <= MSEQ_DONE;
               end else if (w_tc) begin
                  r_timeout_err <= 1'b1;
                  r_state       <= MSEQ_IDLE;
               end
            end
            MSEQ_DRAIN: begin
               if (!bus.flush) begin
                  if (bus.mult_done) begin
                     r_state <= MSEQ_IDLE;
                  end else if (w_tc) begin
                     r_timeout_err <= 1'b1;
                     r_state       <= MSEQ_IDLE;
                  end
               end
            end
            default: r_state <= MSEQ_IDLE;
         endcase
      end
   end

   assign bus.mult_start         = r_mult_start;
   assign bus.mult_mode          = r_mult_mode;
   assign bus.stall              = w_stall;
   assign bus.execute_result_loc = r_exec_loc;
   assign bus.result             = r_result;
   assign bus.result_valid       = r_result_valid;
   assign bus.result_rd          = r_result_rd;
   assign bus.timeout_err        = r_timeout_err;
   assign bus.dbg_state          = r_state;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: randomized multiplies, back-to-back
// issue, flush/drain, lost-done timeout and asynchronous reset.
module tb_mult_sequencer;
   import mult_sequencer_pkg::*;

   localparam int WORD = 64;
   localparam int TO   = 80;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   mult_sequencer_if #(.WORD(WORD)) bus ();

   mult_sequencer #(
      .WORD           (WORD),
      .TIMEOUT_CYCLES (TO),
      .CNT_W          (7)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Expected writeback as {rd, product}, oldest first.
   logic [WORD+4:0] exp_q[$];
   logic [WORD+4:0] last_exp;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.mul_req     = 1'b0;
      bus.mul_mode_in = '0;
      bus.mul_rd      = '0;
      bus.flush       = 1'b0;
      bus.mult_done   = 1'b0;
      bus.mult_result = '0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle_inputs();
      repeat (2) tick();
      @(negedge clk);
      n_tests++;
      if ({bus.mult_start, bus.stall, bus.execute_result_loc, bus.result_valid, bus.timeout_err} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got start/stall/loc/valid/terr=%b want 00000",
                  {bus.mult_start, bus.stall, bus.execute_result_loc, bus.result_valid, bus.timeout_err});
      end
      n_tests++;
      if (bus.result !== '0 || bus.result_rd !== '0 || bus.mult_mode !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got result=%h rd=%0d mode=%b want all 0", bus.result, bus.result_rd, bus.mult_mode);
      end
      reset    = 1'b1;
      last_exp = '0;
      tick();
   endtask

   task automatic test_basic();
      logic [1:0]      mode;
      logic [4:0]      rd;
      logic [WORD-1:0] res;
      logic [WORD+4:0] exp;
      int              lat;
      bit              ok;
      for (int i = 0; i < 7; i++) begin
         mode = (i == 0) ? 2'b01 : 2'($urandom_range(0, 3));
         rd   = (i == 0) ? 5'd5 : 5'($urandom_range(0, 31));
         lat  = (i == 0) ? 64 : int'($urandom_range(1, 70));
         res  = (i == 0) ? 64'h2A : {$urandom, $urandom};
         exp_q.push_back({rd, res});
         bus.mul_req = 1'b1; bus.mul_mode_in = mode; bus.mul_rd = rd;
         @(negedge clk);
         n_tests++;
         if (bus.stall !== 1'b1 || bus.mult_start !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_accept[%0d]: got stall=%b start=%b want stall=1 start=0", i, bus.stall, bus.mult_start);
         end
         tick();
         bus.mul_req = 1'b0; bus.mul_mode_in = ~mode; bus.mul_rd = ~rd;
         @(negedge clk);
         n_tests++;
         if (bus.mult_start !== 1'b1 || bus.mult_mode !== mode || bus.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_start[%0d]: got start=%b mode=%b stall=%b want 1 %b 1", i, bus.mult_start, bus.mult_mode, bus.stall, mode);
         end
         tick();
         ok = 1'b1;
         for (int c = 1; c <= lat; c++) begin
            bus.mult_done   = (c == lat);
            bus.mult_result = (c == lat) ? res : {$urandom, $urandom};
            @(negedge clk);
            if (bus.mult_start !== 1'b0 || bus.stall !== 1'b1 || bus.result_valid !== 1'b0 || bus.mult_mode !== mode) ok = 1'b0;
            tick();
         end
         bus.mult_done = 1'b0;
         n_tests++;
         if (!ok) begin
            n_fail++;
            $display("FAIL basic_busy[%0d]: got a busy-cycle glitch on start/stall/valid/mode want steady 0/1/0/%b", i, mode);
         end
         @(negedge clk);
         exp = exp_q.pop_front();
         n_tests++;
         if (bus.result_valid !== 1'b1 || bus.execute_result_loc !== 1'b1 ||
             {bus.result_rd, bus.result} !== exp || bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done[%0d]: got valid=%b loc=%b rd=%0d res=%h stall=%b want 1 1 rd=%0d res=%h stall=0",
                     i, bus.result_valid, bus.execute_result_loc, bus.result_rd, bus.result, bus.stall,
                     exp[WORD+4:WORD], exp[WORD-1:0]);
         end
         last_exp = exp;
         tick();
         @(negedge clk);
         n_tests++;
         if (bus.result_valid !== 1'b0 || bus.execute_result_loc !== 1'b0 ||
             {bus.result_rd, bus.result} !== last_exp || bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_after[%0d]: got valid=%b loc=%b res=%h stall=%b want 0 0 held res=%h 0",
                     i, bus.result_valid, bus.execute_result_loc, bus.result, bus.stall, last_exp[WORD-1:0]);
         end
         tick();
      end
   endtask

   task automatic test_done_ignored();
      logic [1:0]      mode;
      logic [4:0]      rd;
      logic [WORD-1:0] res;
      int              lat;
      bit              ok;
      bus.mult_done = 1'b1; bus.mult_result = {$urandom, $urandom};
      @(negedge clk);
      tick();
      bus.mult_done = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.result_valid !== 1'b0 || {bus.result_rd, bus.result} !== last_exp || bus.stall !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_done: got valid=%b res=%h stall=%b want 0 res=%h 0", bus.result_valid, bus.result, bus.stall, last_exp[WORD-1:0]);
      end
      tick();
      mode = 2'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 31));
      res  = {$urandom, $urandom};     lat = int'($urandom_range(3, 10));
      bus.mul_req = 1'b1; bus.mul_mode_in = mode; bus.mul_rd = rd;
      @(negedge clk);
      tick();
      bus.mul_req = 1'b0; bus.mult_done = 1'b1; bus.mult_result = ~res;
      @(negedge clk);
      tick();
      ok = 1'b1;
      for (int c = 1; c <= lat; c++) begin
         bus.mult_done   = (c == lat);
         bus.mult_result = res;
         @(negedge clk);
         if (bus.result_valid !== 1'b0 || bus.stall !== 1'b1) ok = 1'b0;
         tick();
      end
      bus.mult_done = 1'b0;
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL start_done_ignored: got early result_valid or stall drop want op still busy");
      end
      @(negedge clk);
      n_tests++;
      if (bus.result_valid !== 1'b1 || bus.result !== res || bus.result_rd !== rd) begin
         n_fail++;
         $display("FAIL start_done_result: got valid=%b rd=%0d res=%h want 1 rd=%0d res=%h", bus.result_valid, bus.result_rd, bus.result, rd, res);
      end
      last_exp = {rd, res};
      tick();
   endtask

   task automatic test_back_to_back();
      logic [1:0]      mode;
      logic [4:0]      rd;
      logic [WORD-1:0] res;
      logic [WORD+4:0] exp;
      int              lat;
      bit              ok;
      ok = 1'b1;
      for (int k = 0; k <= 4; k++) begin
         bus.mult_done = 1'b0;
         if (k < 4) begin
            mode = 2'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 31));
            res  = {$urandom, $urandom};     lat = int'($urandom_range(1, 20));
            bus.mul_req = 1'b1; bus.mul_mode_in = mode; bus.mul_rd = rd;
         end else begin
            bus.mul_req = 1'b0;
         end
         @(negedge clk);
         if (k > 0) begin
            exp = exp_q.pop_front();
            last_exp = exp;
            n_tests++;
            if (bus.result_valid !== 1'b1 || {bus.result_rd, bus.result} !== exp) begin
               n_fail++;
               $display("FAIL b2b_result[%0d]: got valid=%b rd=%0d res=%h want 1 rd=%0d res=%h",
                        k, bus.result_valid, bus.result_rd, bus.result, exp[WORD+4:WORD], exp[WORD-1:0]);
            end
         end
         if (k == 4) begin
            n_tests++;
            if (bus.stall !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_release: got stall=%b want 0", bus.stall);
            end
            tick();
            break;
         end
         if (bus.stall !== 1'b1) ok = 1'b0;
         exp_q.push_back({rd, res});
         tick();
         bus.mul_req = 1'b0; bus.mul_mode_in = ~mode;
         @(negedge clk);
         n_tests++;
         if (bus.mult_start !== 1'b1 || bus.mult_mode !== mode) begin
            n_fail++;
            $display("FAIL b2b_start[%0d]: got start=%b mode=%b want 1 %b", k, bus.mult_start, bus.mult_mode, mode);
         end
         if (bus.stall !== 1'b1) ok = 1'b0;
         tick();
         for (int c = 1; c <= lat; c++) begin
            bus.mult_done   = (c == lat);
            bus.mult_result = res;
            @(negedge clk);
            if (bus.stall !== 1'b1 || bus.result_valid !== 1'b0) ok = 1'b0;
            tick();
         end
      end
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL b2b_stall: got stall low during chained ops want continuously 1");
      end
   endtask

   task automatic test_flush_busy();
      logic [1:0]      mode0, mode1;
      logic [4:0]      rd1;
      logic [WORD-1:0] res1;
      int              f, dd, r, lat;
      bit              ok;
      for (int v = 0; v < 4; v++) begin
         f  = (v == 0) ? 1 : (v == 1) ? 10 : int'($urandom_range(2, 20));
         dd = (v == 1) ? 64 : int'($urandom_range(f + 1, 70));
         r  = (v == 1) ? 20 : int'($urandom_range(f + 1, dd));
         mode0 = 2'($urandom_range(0, 3));
         mode1 = 2'($urandom_range(0, 3)); rd1 = 5'($urandom_range(0, 31));
         res1  = {$urandom, $urandom};     lat = int'($urandom_range(1, 10));
         bus.mul_req = 1'b1; bus.mul_mode_in = mode0; bus.mul_rd = 5'($urandom_range(0, 31));
         @(negedge clk);
         tick();
         ok = 1'b1;
         for (int t = 1; t <= dd; t++) begin
            bus.flush       = (t == f);
            bus.mult_done   = (t == dd);
            bus.mult_result = {$urandom, $urandom};
            bus.mul_req     = (t >= r);
            bus.mul_mode_in = mode1;
            bus.mul_rd      = rd1;
            @(negedge clk);
            if (bus.stall !== 1'b1 || bus.result_valid !== 1'b0) ok = 1'b0;
            if (t == 1 && bus.mult_start !== 1'b1) ok = 1'b0;
            if (t > 1 && bus.mult_start !== 1'b0) ok = 1'b0;
            tick();
         end
         bus.flush = 1'b0; bus.mult_done = 1'b0;
         n_tests++;
         if (!ok) begin
            n_fail++;
            $display("FAIL flush_drain[%0d]: got wrong stall/valid/start while draining (f=%0d done=%0d req=%0d)", v, f, dd, r);
         end
         @(negedge clk);
         n_tests++;
         if (bus.stall !== 1'b1 || bus.mult_start !== 1'b0 || bus.result_valid !== 1'b0 ||
             {bus.result_rd, bus.result} !== last_exp) begin
            n_fail++;
            $display("FAIL flush_reentry[%0d]: got stall=%b start=%b valid=%b res=%h want 1 0 0 res=%h",
                     v, bus.stall, bus.mult_start, bus.result_valid, bus.result, last_exp[WORD-1:0]);
         end
         tick();
         bus.mul_req = 1'b0;
         @(negedge clk);
         n_tests++;
         if (bus.mult_start !== 1'b1 || bus.mult_mode !== mode1) begin
            n_fail++;
            $display("FAIL flush_restart[%0d]: got start=%b mode=%b want 1 %b", v, bus.mult_start, bus.mult_mode, mode1);
         end
         tick();
         for (int c = 1; c <= lat; c++) begin
            bus.mult_done   = (c == lat);
            bus.mult_result = res1;
            @(negedge clk);
            tick();
         end
         bus.mult_done = 1'b0;
         @(negedge clk);
         n_tests++;
         if (bus.result_valid !== 1'b1 || bus.result !== res1 || bus.result_rd !== rd1) begin
            n_fail++;
            $display("FAIL flush_next_result[%0d]: got valid=%b rd=%0d res=%h want 1 rd=%0d res=%h",
                     v, bus.result_valid, bus.result_rd, bus.result, rd1, res1);
         end
         last_exp = {rd1, res1};
         tick();
      end
   endtask

   task automatic test_flush_done();
      logic [4:0]      rd;
      logic [WORD-1:0] res;
      int              lat;
      lat = int'($urandom_range(2, 30));
      bus.mul_req = 1'b1; bus.mul_mode_in = 2'($urandom_range(0, 3)); bus.mul_rd = 5'($urandom_range(0, 31));
      @(negedge clk);
      tick();
      bus.mul_req = 1'b0;
      for (int c = 0; c <= lat; c++) begin
         bus.mult_done   = (c == lat);
         bus.flush       = (c == lat);
         bus.mult_result = {$urandom, $urandom};
         @(negedge clk);
         tick();
      end
      bus.mult_done = 1'b0; bus.flush = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.result_valid !== 1'b0 || bus.stall !== 1'b0 || bus.execute_result_loc !== 1'b0 ||
          {bus.result_rd, bus.result} !== last_exp) begin
         n_fail++;
         $display("FAIL flush_with_done: got valid=%b stall=%b loc=%b res=%h want 0 0 0 res=%h",
                  bus.result_valid, bus.stall, bus.execute_result_loc, bus.result, last_exp[WORD-1:0]);
      end
      tick();
      bus.mul_req = 1'b1; bus.flush = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus.stall !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_idle_stall: got stall=%b want 0", bus.stall);
      end
      tick();
      bus.mul_req = 1'b0; bus.flush = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.mult_start !== 1'b0 || bus.stall !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_idle_req: got start=%b stall=%b want 0 0", bus.mult_start, bus.stall);
      end
      tick();
      rd = 5'($urandom_range(0, 31)); res = {$urandom, $urandom}; lat = int'($urandom_range(1, 10));
      bus.mul_req = 1'b1; bus.mul_rd = rd;
      @(negedge clk);
      tick();
      bus.mul_req = 1'b0;
      for (int c = 0; c <= lat; c++) begin
         bus.mult_done   = (c == lat);
         bus.mult_result = res;
         @(negedge clk);
         tick();
      end
      bus.mult_done = 1'b0; bus.mul_req = 1'b1; bus.flush = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus.result_valid !== 1'b1 || bus.result !== res || bus.result_rd !== rd || bus.stall !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_in_done: got valid=%b rd=%0d res=%h stall=%b want 1 rd=%0d res=%h 0",
                  bus.result_valid, bus.result_rd, bus.result, bus.stall, rd, res);
      end
      last_exp = {rd, res};
      tick();
      bus.mul_req = 1'b0; bus.flush = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.mult_start !== 1'b0 || bus.stall !== 1'b0 || bus.result_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_done_after: got start=%b stall=%b valid=%b want 0 0 0", bus.mult_start, bus.stall, bus.result_valid);
      end
      tick();
   endtask

   task automatic test_timeout();
      logic [WORD-1:0] res;
      bit              ok;
      res = {$urandom, $urandom};
      bus.mul_req = 1'b1;
      @(negedge clk);
      tick();
      bus.mul_req = 1'b0;
      for (int t = 1; t <= TO + 1; t++) begin
         bus.mult_done   = (t == TO + 1);
         bus.mult_result = res;
         @(negedge clk);
         tick();
      end
      bus.mult_done = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.result_valid !== 1'b1 || bus.result !== res || bus.timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_last_cycle_done: got valid=%b res=%h terr=%b want 1 res=%h 0", bus.result_valid, bus.result, bus.timeout_err, res);
      end
      last_exp = {bus.result_rd, res};
      tick();
      for (int pass = 0; pass < 2; pass++) begin
         bus.mul_req = 1'b1;
         @(negedge clk);
         tick();
         bus.mul_req = 1'b0;
         ok = 1'b1;
         for (int t = 1; t <= TO + 1; t++) begin
            bus.flush = (pass == 1 && t == 5);
            @(negedge clk);
            if (bus.stall !== 1'b1 || bus.result_valid !== 1'b0) ok = 1'b0;
            if (pass == 0 && bus.timeout_err !== 1'b0) ok = 1'b0;
            tick();
         end
         bus.flush = 1'b0;
         n_tests++;
         if (!ok) begin
            n_fail++;
            $display("FAIL timeout_wait[%0d]: got early stall drop, valid or error want stall=1 for %0d cycles", pass, TO + 1);
         end
         @(negedge clk);
         n_tests++;
         if (bus.timeout_err !== 1'b1 || bus.stall !== 1'b0 || bus.result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_fire[%0d]: got terr=%b stall=%b valid=%b want 1 0 0", pass, bus.timeout_err, bus.stall, bus.result_valid);
         end
         tick();
      end
      bus.mul_req = 1'b1;
      @(negedge clk);
      tick();
      bus.mul_req = 1'b0;
      for (int c = 0; c <= 3; c++) begin
         bus.mult_done = (c == 3);
         @(negedge clk);
         tick();
      end
      bus.mult_done = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.timeout_err !== 1'b1 || bus.result_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_sticky: got terr=%b valid=%b want 1 1", bus.timeout_err, bus.result_valid);
      end
      last_exp = {bus.result_rd, bus.result};
      tick();
   endtask

   task automatic test_async_reset();
      bus.mul_req = 1'b1; bus.mul_mode_in = 2'b11; bus.mul_rd = 5'd17;
      @(negedge clk);
      tick();
      bus.mul_req = 1'b0;
      repeat (6) tick();
      #2;
      reset = 1'b0;
      #1;
      n_tests++;
      if ({bus.mult_start, bus.stall, bus.execute_result_loc, bus.result_valid, bus.timeout_err} !== 5'b0 ||
          bus.mult_mode !== '0 || bus.result_rd !== '0 || bus.result !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got start/stall/loc/valid/terr=%b mode=%b rd=%0d res=%h want all 0",
                  {bus.mult_start, bus.stall, bus.execute_result_loc, bus.result_valid, bus.timeout_err},
                  bus.mult_mode, bus.result_rd, bus.result);
      end
      @(negedge clk);
      reset = 1'b1;
      tick();
      bus.mult_done = 1'b1; bus.mult_result = {$urandom, $urandom};
      @(negedge clk);
      tick();
      bus.mult_done = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.result_valid !== 1'b0 || bus.result !== '0 || bus.stall !== 1'b0 || bus.mult_start !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_done: got valid=%b res=%h stall=%b start=%b want 0 0 0 0",
                  bus.result_valid, bus.result, bus.stall, bus.mult_start);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_done_ignored();
      test_back_to_back();
      test_flush_busy();
      test_flush_done();
      test_timeout();
      test_async_reset();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending results want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: got simulation time limit want completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "time limit");
   end

endmodule
